// File: rtl/error_frame_ctrl.sv
// Error-frame sequencer for a CAN-style node: drives error flag and delimiter,
// maintains TEC/REC fault-confinement counters and handles bus-off recovery.
module error_frame_ctrl #(
  parameter int FLAG_LEN  = 6,
  parameter int DELIM_LEN = 8,
  parameter int RECOV_SEQ = 128
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SP,
  input  logic       RX_BIT,
  input  logic       STF_E,
  input  logic       EOF_E,
  input  logic       CRC_E,
  input  logic       FRM_E,
  input  logic       IS_TX,
  input  logic       FRAME_OK,
  output logic       TX_BIT,
  output logic       ERROR,
  output logic [1:0] ERR_STATE,
  output logic [8:0] TEC,
  output logic [7:0] REC,
  output logic [2:0] o_dbg_state
);

  localparam int FCW = $clog2(FLAG_LEN + 1);
  localparam int DCW = $clog2(DELIM_LEN + 1);
  localparam int SCW = $clog2(RECOV_SEQ + 1);
  localparam logic [FCW-1:0] FLAG_LAST  = FCW'(FLAG_LEN);
  localparam logic [DCW-1:0] DELIM_LAST = DCW'(DELIM_LEN);
  localparam logic [SCW-1:0] SEQ_LAST   = SCW'(RECOV_SEQ);
  localparam logic [3:0]     RUN_LAST   = 4'd10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FLAG   = 3'd1,
    S_DWAIT  = 3'd2,
    S_DELIM  = 3'd3,
    S_BUSOFF = 3'd4
  } state_t;

  state_t         r_state;
  logic [8:0]     r_tec;
  logic [7:0]     r_rec;
  logic [FCW-1:0] r_flag_cnt;
  logic [DCW-1:0] r_delim_cnt;
  logic [3:0]     r_run_cnt;
  logic [SCW-1:0] r_seq_cnt;
  logic           r_tx_bit;
  logic           r_error;

  state_t         w_state_nxt;
  logic [8:0]     w_tec_nxt;
  logic [7:0]     w_rec_nxt;
  logic [FCW-1:0] w_flag_nxt;
  logic [DCW-1:0] w_delim_nxt;
  logic [3:0]     w_run_nxt;
  logic [SCW-1:0] w_seq_nxt;
  logic           w_tx_nxt;
  logic           w_error_nxt;
  logic           w_raise;
  logic           w_err_evt;
  logic [DCW-1:0] w_delim_inc;
  logic [SCW-1:0] w_seq_inc;

  // TEC >= 256 is exactly bit 8; below that, bit 7 marks >= 128.
  function automatic logic [1:0] f_err_state(input logic [8:0] tec, input logic [7:0] rec);
    if (tec[8]) return 2'b10;
    else if (tec[7] || rec[7]) return 2'b01;
    else return 2'b00;
  endfunction

  assign w_err_evt   = ~(STF_E & EOF_E & CRC_E & FRM_E);
  assign w_delim_inc = r_delim_cnt + 1'b1;
  assign w_seq_inc   = r_seq_cnt + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_tec_nxt   = r_tec;
    w_rec_nxt   = r_rec;
    w_flag_nxt  = r_flag_cnt;
    w_delim_nxt = r_delim_cnt;
    w_run_nxt   = r_run_cnt;
    w_seq_nxt   = r_seq_cnt;
    w_raise     = 1'b0;
    if (SP) begin
      case (r_state)
        S_IDLE: begin
          if (w_err_evt) begin
            w_raise = 1'b1;
          end else if (FRAME_OK) begin
            if (IS_TX) begin
              if (r_tec != 9'd0) w_tec_nxt = r_tec - 9'd1;
            end else if (r_rec != 8'd0) begin
              w_rec_nxt = r_rec - 8'd1;
            end
          end
        end
        S_FLAG: begin
          if (r_flag_cnt == FLAG_LAST) begin
            w_state_nxt = S_DWAIT;
            w_flag_nxt  = '0;
          end else begin
            w_flag_nxt = r_flag_cnt + 1'b1;
          end
        end
        S_DWAIT: begin
          // The first recessive sample already counts as delimiter bit one.
          if (RX_BIT) begin
            w_state_nxt = S_DELIM;
            w_delim_nxt = DCW'(1);
          end
        end
        S_DELIM: begin
          if (!RX_BIT) begin
            w_raise = 1'b1;
          end else if (w_delim_inc == DELIM_LAST) begin
            w_state_nxt = S_IDLE;
            w_delim_nxt = '0;
          end else begin
            w_delim_nxt = w_delim_inc;
          end
        end
        S_BUSOFF: begin
          if (!RX_BIT) begin
            w_run_nxt = '0;
          end else if (r_run_cnt == RUN_LAST) begin
            w_run_nxt = '0;
            if (w_seq_inc == SEQ_LAST) begin
              w_seq_nxt   = '0;
              w_tec_nxt   = 9'd0;
              w_rec_nxt   = 8'd0;
              w_state_nxt = S_IDLE;
            end else begin
              w_seq_nxt = w_seq_inc;
            end
          end else begin
            w_run_nxt = r_run_cnt + 4'd1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase

      // Raising an error: TEC is always below 256 here, so +8 fits in 9 bits.
      if (w_raise) begin
        w_delim_nxt = '0;
        if (IS_TX) w_tec_nxt = r_tec + 9'd8;
        else if (r_rec != 8'hFF) w_rec_nxt = r_rec + 8'd1;
        if (w_tec_nxt[8]) begin
          w_state_nxt = S_BUSOFF;
          w_run_nxt   = '0;
          w_seq_nxt   = '0;
          w_flag_nxt  = '0;
        end else begin
          w_state_nxt = S_FLAG;
          w_flag_nxt  = FCW'(1);
        end
      end
    end

    w_tx_nxt = 1'b1;
    if (w_state_nxt == S_FLAG && f_err_state(w_tec_nxt, w_rec_nxt) == 2'b00) w_tx_nxt = 1'b0;
    w_error_nxt = (w_state_nxt == S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_tec       <= 9'd0;
      r_rec       <= 8'd0;
      r_flag_cnt  <= '0;
      r_delim_cnt <= '0;
      r_run_cnt   <= '0;
      r_seq_cnt   <= '0;
      r_tx_bit    <= 1'b1;
      r_error     <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_tec       <= w_tec_nxt;
      r_rec       <= w_rec_nxt;
      r_flag_cnt  <= w_flag_nxt;
      r_delim_cnt <= w_delim_nxt;
      r_run_cnt   <= w_run_nxt;
      r_seq_cnt   <= w_seq_nxt;
      r_tx_bit    <= w_tx_nxt;
      r_error     <= w_error_nxt;
    end
  end

  assign TX_BIT      = r_tx_bit;
  assign ERROR       = r_error;
  assign TEC         = r_tec;
  assign REC         = r_rec;
  assign ERR_STATE   = f_err_state(r_tec, r_rec);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_error_frame_ctrl.sv
// Bench for error_frame_ctrl: a reference model feeds an expected-output queue
// per sample point, plus directed checks of the key error-frame scenarios.
module tb_error_frame_ctrl;

  localparam int FLAG_LEN  = 6;
  localparam int DELIM_LEN = 8;
  localparam int RECOV_SEQ = 128;

  localparam logic [3:0] NO_ERR  = 4'b1111;  // {STF,EOF,CRC,FRM}
  localparam logic [3:0] STF_ERR = 4'b0111;
  localparam logic [3:0] CRC_ERR = 4'b1101;
  localparam logic [3:0] FRM_ERR = 4'b1110;

  localparam int M_IDLE = 0, M_FLAG = 1, M_DWAIT = 2, M_DELIM = 3, M_BUSOFF = 4;

  logic       clk;
  logic       reset;
  logic       sp;
  logic       rx_bit;
  logic [3:0] flags;
  logic       is_tx;
  logic       frame_ok;
  logic       tx_bit;
  logic       error_n;
  logic [1:0] err_state;
  logic [8:0] tec;
  logic [7:0] rec;
  logic [2:0] dbg_state;

  logic [20:0] exp_q[$];
  int n_checks;
  int n_errors;

  int m_state, m_tec, m_rec, m_fc, m_dc, m_run, m_seq;

  error_frame_ctrl #(
    .FLAG_LEN (FLAG_LEN),
    .DELIM_LEN(DELIM_LEN),
    .RECOV_SEQ(RECOV_SEQ)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .SP         (sp),
    .RX_BIT     (rx_bit),
    .STF_E      (flags[3]),
    .EOF_E      (flags[2]),
    .CRC_E      (flags[1]),
    .FRM_E      (flags[0]),
    .IS_TX      (is_tx),
    .FRAME_OK   (frame_ok),
    .TX_BIT     (tx_bit),
    .ERROR      (error_n),
    .ERR_STATE  (err_state),
    .TEC        (tec),
    .REC        (rec),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_es(input int t, input int r);
    if (t >= 256) return 2;
    if (t >= 128 || r >= 128) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    m_state = M_IDLE; m_tec = 0; m_rec = 0;
    m_fc = 0; m_dc = 0; m_run = 0; m_seq = 0;
  endtask

  // Reference behaviour for one sample point; pushes expected outputs.
  task automatic model_sp(input logic rx, input logic [3:0] fl, input logic tx, input logic fok);
    bit raise;
    int es;
    logic exp_tx;
    logic exp_err;
    raise = 0;
    case (m_state)
      M_IDLE: begin
        if (fl != 4'hF) raise = 1;
        else if (fok) begin
          if (tx) m_tec = (m_tec > 0) ? m_tec - 1 : 0;
          else    m_rec = (m_rec > 0) ? m_rec - 1 : 0;
        end
      end
      M_FLAG: begin
        if (m_fc == FLAG_LEN) m_state = M_DWAIT;
        else m_fc++;
      end
      M_DWAIT: if (rx) begin m_state = M_DELIM; m_dc = 1; end
      M_DELIM: begin
        if (!rx) raise = 1;
        else begin
          m_dc++;
          if (m_dc == DELIM_LEN) m_state = M_IDLE;
        end
      end
      default: begin
        if (!rx) m_run = 0;
        else begin
          m_run++;
          if (m_run == 11) begin
            m_run = 0;
            m_seq++;
            if (m_seq == RECOV_SEQ) begin
              m_seq = 0; m_tec = 0; m_rec = 0; m_state = M_IDLE;
            end
          end
        end
      end
    endcase
    if (raise) begin
      if (tx) m_tec += 8;
      else if (m_rec < 255) m_rec++;
      if (m_tec >= 256) begin m_state = M_BUSOFF; m_run = 0; m_seq = 0; end
      else begin m_state = M_FLAG; m_fc = 1; end
    end
    es = model_es(m_tec, m_rec);
    exp_tx  = !(m_state == M_FLAG && es == 0);
    exp_err = (m_state == M_IDLE);
    exp_q.push_back({exp_tx, exp_err, 2'(es), 9'(m_tec), 8'(m_rec)});
  endtask

  // driver: one bit time = SP clock followed by one SP=0 clock
  task automatic drive_bit(input logic rx, input logic [3:0] fl, input logic tx, input logic fok);
    logic [20:0] exp;
    @(negedge clk);
    sp = 1'b1; rx_bit = rx; flags = fl; is_tx = tx; frame_ok = fok;
    model_sp(rx, fl, tx, fok);
    @(negedge clk);
    sp = 1'b0; flags = NO_ERR; frame_ok = 1'b0;
    if (exp_q.size() == 0) begin
      check_eq("sb_queue_empty", 32'd0, 32'd1);
    end else begin
      exp = exp_q.pop_front();
      check_eq("sb_outputs", {11'd0, tx_bit, error_n, err_state, tec, rec}, {11'd0, exp});
    end
  endtask

  task automatic err_frame(input logic [3:0] fl, input logic tx);
    drive_bit(1'b1, fl, tx, 1'b0);
    repeat (FLAG_LEN + DELIM_LEN) drive_bit(1'b1, NO_ERR, tx, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int tx0, e0;
    n_checks = 0; n_errors = 0;
    reset = 1'b1; sp = 1'b0; rx_bit = 1'b1; flags = NO_ERR; is_tx = 1'b0; frame_ok = 1'b0;
    model_reset();
    do_reset();
    @(negedge clk);
    check_eq("rst_tx", tx_bit, 1);
    check_eq("rst_error", error_n, 1);
    check_eq("rst_es", err_state, 0);
    check_eq("rst_tec", tec, 0);
    check_eq("rst_rec", rec, 0);

    // receiver CRC error: 6 dominant flag bits, 14 bits of error frame
    drive_bit(1'b1, CRC_ERR, 1'b0, 1'b0);
    check_eq("rx_crc_rec", rec, 1);
    tx0 = (tx_bit == 1'b0) ? 1 : 0;
    e0  = (error_n == 1'b0) ? 1 : 0;
    repeat (FLAG_LEN + DELIM_LEN) begin
      drive_bit(1'b1, NO_ERR, 1'b0, 1'b0);
      tx0 += (tx_bit == 1'b0) ? 1 : 0;
      e0  += (error_n == 1'b0) ? 1 : 0;
    end
    check_eq("rx_crc_flag_bits", tx0, 6);
    check_eq("rx_crc_error_bits", e0, 14);
    check_eq("rx_crc_done", error_n, 1);

    // FRAME_OK decrements and floors
    drive_bit(1'b1, NO_ERR, 1'b0, 1'b1);
    check_eq("rec_dec", rec, 0);
    drive_bit(1'b1, NO_ERR, 1'b0, 1'b1);
    check_eq("rec_floor", rec, 0);
    drive_bit(1'b1, NO_ERR, 1'b1, 1'b1);
    check_eq("tec_floor", tec, 0);

    repeat (5) err_frame(CRC_ERR, 1'b0);
    check_eq("rec_five", rec, 5);
    // error and FRAME_OK together: error wins
    drive_bit(1'b1, STF_ERR, 1'b0, 1'b1);
    check_eq("err_ok_rec", rec, 6);
    check_eq("err_ok_state", dbg_state, M_FLAG);
    repeat (FLAG_LEN + DELIM_LEN) drive_bit(1'b1, NO_ERR, 1'b0, 1'b0);

    // dominant bit inside delimiter restarts the flag
    drive_bit(1'b1, CRC_ERR, 1'b0, 1'b0);
    repeat (FLAG_LEN + 1) drive_bit(1'b1, NO_ERR, 1'b0, 1'b0);
    repeat (2) drive_bit(1'b1, NO_ERR, 1'b0, 1'b0);
    check_eq("delim_state", dbg_state, M_DELIM);
    drive_bit(1'b0, NO_ERR, 1'b0, 1'b0);
    check_eq("delim_err_rec", rec, 8);
    check_eq("delim_err_state", dbg_state, M_FLAG);
    check_eq("delim_err_tx", tx_bit, 0);
    repeat (FLAG_LEN - 1) drive_bit(1'b1, NO_ERR, 1'b0, 1'b0);
    check_eq("reflag_still", dbg_state, M_FLAG);
    drive_bit(1'b1, NO_ERR, 1'b0, 1'b0);
    check_eq("reflag_dwait", dbg_state, M_DWAIT);
    repeat (DELIM_LEN) drive_bit(1'b1, NO_ERR, 1'b0, 1'b0);
    check_eq("reflag_idle", dbg_state, M_IDLE);

    // transmitter: 16 error frames to error-passive
    do_reset();
    repeat (16) err_frame(FRM_ERR, 1'b1);
    check_eq("tx16_tec", tec, 128);
    check_eq("tx16_es", err_state, 1);
    drive_bit(1'b1, FRM_ERR, 1'b1, 1'b0);
    check_eq("passive_flag_state", dbg_state, M_FLAG);
    check_eq("passive_flag_tx", tx_bit, 1);
    repeat (FLAG_LEN + DELIM_LEN) drive_bit(1'b1, NO_ERR, 1'b1, 1'b0);

    // walk TEC to 250, then into bus-off
    repeat (14) err_frame(FRM_ERR, 1'b1);
    repeat (6) drive_bit(1'b1, NO_ERR, 1'b1, 1'b1);
    err_frame(FRM_ERR, 1'b1);
    check_eq("tec_250", tec, 250);
    drive_bit(1'b1, FRM_ERR, 1'b1, 1'b0);
    check_eq("busoff_tec", tec, 258);
    check_eq("busoff_es", err_state, 2);
    check_eq("busoff_state", dbg_state, M_BUSOFF);
    check_eq("busoff_error", error_n, 0);
    check_eq("busoff_tx", tx_bit, 1);
    repeat (5) drive_bit(1'b1, CRC_ERR, 1'b1, 1'b1);
    drive_bit(1'b0, NO_ERR, 1'b1, 1'b0);
    repeat (RECOV_SEQ * 11 - 1) drive_bit(1'b1, NO_ERR, 1'b1, 1'b0);
    check_eq("busoff_hold_state", dbg_state, M_BUSOFF);
    check_eq("busoff_hold_tec", tec, 258);
    drive_bit(1'b1, NO_ERR, 1'b1, 1'b0);
    check_eq("recov_tec", tec, 0);
    check_eq("recov_rec", rec, 0);
    check_eq("recov_es", err_state, 0);
    check_eq("recov_error", error_n, 1);

    // random traffic through the scoreboard
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [3:0] fl;
      fl = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 14)) : NO_ERR;
      drive_bit(($urandom_range(0, 3) != 0), fl, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // asynchronous reset during a flag
    do_reset();
    drive_bit(1'b1, FRM_ERR, 1'b1, 1'b0);
    repeat (2) drive_bit(1'b1, NO_ERR, 1'b1, 1'b0);
    check_eq("pre_areset_state", dbg_state, M_FLAG);
    #2 reset = 1'b0;
    #1;
    check_eq("areset_tx", tx_bit, 1);
    check_eq("areset_error", error_n, 1);
    check_eq("areset_tec", tec, 0);
    check_eq("areset_rec", rec, 0);
    check_eq("areset_state", dbg_state, M_IDLE);
    model_reset();
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    drive_bit(1'b1, CRC_ERR, 1'b0, 1'b0);
    check_eq("post_reset_rec", rec, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/error_frame_ctrl.md
ERROR_FRAME_CTRL -- requirements
Module: error_frame_ctrl

Interface
REQ-001 Parameter FLAG_LEN, 6, error-flag length in bit times.
REQ-002 Parameter DELIM_LEN, 8, error-delimiter length in bit times (recessive bits).
REQ-003 Parameter RECOV_SEQ, 128, count of 11-recessive-bit sequences required for bus-off recovery.
REQ-004 clk  in  1  single system clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 SP  in  1  sample-point strobe, one clk cycle wide per bit time; all other inputs qualified by SP=1.
REQ-007 RX_BIT  in  1  sampled bus level, 0 = dominant.
REQ-008 STF_E, EOF_E, CRC_E, FRM_E  in  1 each  active-low error flags (stuff, EOF, CRC, form).
REQ-009 IS_TX  in  1  1 = node is transmitter of current frame.
REQ-010 FRAME_OK  in  1  with SP: current frame completed without error.
REQ-011 TX_BIT  out  1  level to drive on bus, 1 = recessive; registered.
REQ-012 ERROR  out  1  active-low; 0 while error frame or bus-off in progress; registered.
REQ-013 ERR_STATE  out  2  00 error-active, 01 error-passive, 10 bus-off.
REQ-014 TEC  out  9  transmit error counter; REC  out  8  receive error counter.

Function
REQ-015 FSM states IDLE, FLAG, DWAIT, DELIM, BUSOFF; transitions and counter updates occur only on clk edges with SP=1; with SP=0 all state, counters, outputs hold.
REQ-016 Error event = SP=1 and any of STF_E/EOF_E/CRC_E/FRM_E = 0; multiple flags low in one SP count as one event.
REQ-017 IDLE, error event: IS_TX=1 -> TEC+=8, else REC+=1 (REC saturates at 255); next state FLAG, bit counter = 1.
REQ-018 IDLE, FRAME_OK=1, no error event: IS_TX=1 -> TEC-=1, else REC-=1; both floor at 0.
REQ-019 Error event and FRAME_OK on same SP: error handling only, no decrement.
REQ-020 FLAG: TX_BIT=0 if ERR_STATE=00, TX_BIT=1 if 01; after FLAG_LEN SPs in flag -> DWAIT.
REQ-021 DWAIT: TX_BIT=1; stay while RX_BIT=0; RX_BIT=1 at SP -> DELIM with delimiter count = 1.
REQ-022 DELIM: TX_BIT=1; RX_BIT=1 increments count; count reaching DELIM_LEN -> IDLE; RX_BIT=0 -> new error event (counter update per REQ-017), FLAG.
REQ-023 ERROR = 0 in FLAG, DWAIT, DELIM, BUSOFF; 1 in IDLE; TX_BIT = 1 in IDLE and BUSOFF.
REQ-024 ERR_STATE combinational from counters: TEC>=256 -> 10; else TEC>=128 or REC>=128 -> 01; else 00.
REQ-025 TEC reaching >=256 on any update -> BUSOFF immediately (overrides FLAG entry); TEC held, not incremented further.
REQ-026 BUSOFF: count consecutive RX_BIT=1 SPs; 11th recessive increments sequence counter and restarts run; RX_BIT=0 restarts run only.
REQ-027 Sequence counter reaching RECOV_SEQ -> TEC=0, REC=0, IDLE, ERROR=1 on same edge.
REQ-028 Error flags and FRAME_OK ignored outside IDLE/DELIM as specified; ignored entirely in BUSOFF.

Reset
REQ-029 reset=0 asynchronously forces: state IDLE, TEC=0, REC=0, all internal counters 0, TX_BIT=1, ERROR=1, ERR_STATE=00; applies mid-frame and in BUSOFF.
REQ-030 Release of reset takes effect on next clk edge; first SP after release processed normally.

Verification
REQ-031 Receiver, CRC_E=0 at one SP, RX_BIT=1 afterwards -> REC=1, TX_BIT=0 for 6 SPs, then 1; ERROR=0 for 6+8 SPs, then 1.
REQ-032 Transmitter, 16 error frames -> TEC=128, ERR_STATE=01, next flag transmitted with TX_BIT=1.
REQ-033 TEC=250, IS_TX=1, FRM_E=0 -> TEC=258, state BUSOFF, ERR_STATE=10; 128x11 recessive SPs -> TEC=REC=0, ERR_STATE=00, ERROR=1.
REQ-034 IDLE, STF_E=0 and FRAME_OK=1 same SP, IS_TX=0, REC=5 -> REC=6, FLAG entered.
REQ-035 DELIM after 3 recessive, RX_BIT=0 -> REC incremented, FLAG restarted at count 1.
REQ-036 reset=0 asserted between SPs during FLAG -> TX_BIT=1, ERROR=1, TEC=REC=0 before next clk edge.
